// File: rtl/mc_controller_pkg.sv
// mc_controller_pkg: shared definitions for the multi-cycle control unit.
//   - state encodings (exposed on the debug `state` port)
//   - opcode / funct constants of the supported instruction subset
//   - select codes for npc_sel, alu_op, reg_dst and mem_to_reg
//   - inst_class_t: one-hot-ish instruction class flags produced by mc_decode
package mc_controller_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'h0,
        S_DECODE = 4'h1,
        S_MA     = 4'h2,
        S_MR     = 4'h3,
        S_MW     = 4'h4,
        S_WBM    = 4'h5,
        S_EXE    = 4'h6,
        S_WBA    = 4'h7,
        S_BR     = 4'h8,
        S_JMP    = 4'h9,
        S_ILL    = 4'hA,
        S_HALT   = 4'hF
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    localparam logic [1:0] NPC_PC4    = 2'b00;
    localparam logic [1:0] NPC_REG    = 2'b01;
    localparam logic [1:0] NPC_JUMP   = 2'b10;
    localparam logic [1:0] NPC_BRANCH = 2'b11;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_OR  = 2'b10;
    localparam logic [1:0] ALU_LUI = 2'b11;

    localparam logic [1:0] DST_RT  = 2'b00;
    localparam logic [1:0] DST_RD  = 2'b01;
    localparam logic [1:0] DST_R31 = 2'b10;

    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MEM = 2'b01;
    localparam logic [1:0] M2R_PC4 = 2'b10;

    typedef struct packed {
        logic r_arith;   // addu or subu
        logic sub;       // subu
        logic jr;
        logic ori;
        logic lui;
        logic lw;
        logic sw;
        logic beq;
        logic j;
        logic jal;
        logic illegal;
    } inst_class_t;

endpackage

// File: rtl/mc_controller_decode.sv
// mc_decode: purely combinational classification of a latched opcode/funct
// pair into instruction-class flags.
//   op     in  6  latched opcode field
//   funct  in  6  latched funct field (meaningful only when op is R-type)
//   cls    out    instruction class flags; `illegal` set for anything unknown
module mc_decode
    import mc_controller_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    output inst_class_t cls
);

    always_comb begin
        cls = '0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU: cls.r_arith = 1'b1;
                    FN_SUBU: begin
                        cls.r_arith = 1'b1;
                        cls.sub     = 1'b1;
                    end
                    FN_JR:   cls.jr = 1'b1;
                    default: cls.illegal = 1'b1;
                endcase
            end
            OP_ORI:  cls.ori     = 1'b1;
            OP_LUI:  cls.lui     = 1'b1;
            OP_LW:   cls.lw      = 1'b1;
            OP_SW:   cls.sw      = 1'b1;
            OP_BEQ:  cls.beq     = 1'b1;
            OP_J:    cls.j       = 1'b1;
            OP_JAL:  cls.jal     = 1'b1;
            default: cls.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// mc_controller: multi-cycle control FSM downstream of the fetch unit.
// Steps each instruction through FETCH/DECODE/... states and drives the
// datapath enables/selects; pc_wr/npc_sel tell fetch to advance the PC once
// per instruction.
//
// Optional build macro: MC_ILLEGAL_TRAP_EN
//   defined   - unknown encodings enter HALT (state Fh) until reset
//   undefined - unknown encodings go to ILL, a one-cycle nop that advances PC
//
// Ports:
//   clk, reset (async, active-high)
//   instruction  in   fetched word, stable while PC is unchanged
//   zero         in   ALU equality flag, used only in BR
//   pc_wr, npc_sel           PC update strobe / next-PC select
//   ir_wr, reg_wr, mem_wr    write enables
//   reg_dst, alu_src, alu_op, ext_op, mem_to_reg   datapath selects
//   state        out  registered state encoding (debug)
//   retired      out  CNT_W-bit count of completed instructions (wraps)
module mc_controller
    import mc_controller_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instruction,
    input  logic             zero,
    output logic             pc_wr,
    output logic [1:0]       npc_sel,
    output logic             ir_wr,
    output logic             reg_wr,
    output logic [1:0]       reg_dst,
    output logic             alu_src,
    output logic [1:0]       alu_op,
    output logic             ext_op,
    output logic             mem_wr,
    output logic [1:0]       mem_to_reg,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired
);

    state_t           state_q, state_d;
    logic [5:0]       op_q, funct_q;
    logic [CNT_W-1:0] retired_q;
    inst_class_t      cls;
    logic             post_decode;

    // Only opcode and funct steer control; the operand fields belong to the datapath.
    logic unused_fields;
    assign unused_fields = ^instruction[25:6];

    mc_decode u_decode (
        .op    (op_q),
        .funct (funct_q),
        .cls   (cls)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            op_q      <= '0;
            funct_q   <= '0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (ir_wr) begin
                op_q    <= instruction[31:26];
                funct_q <= instruction[5:0];
            end
            if (pc_wr) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                if (cls.lw || cls.sw)                       state_d = S_MA;
                else if (cls.r_arith || cls.ori || cls.lui) state_d = S_EXE;
                else if (cls.beq)                           state_d = S_BR;
                else if (cls.j || cls.jal || cls.jr)        state_d = S_JMP;
                else begin
`ifdef MC_ILLEGAL_TRAP_EN
                    state_d = S_HALT;
`else
                    state_d = S_ILL;
`endif
                end
            end
            S_MA:     state_d = cls.lw ? S_MR : S_MW;
            S_MR:     state_d = S_WBM;
            S_EXE:    state_d = S_WBA;
            S_WBM, S_WBA, S_MW, S_BR, S_JMP, S_ILL: state_d = S_FETCH;
            S_HALT: begin
`ifdef MC_ILLEGAL_TRAP_EN
                state_d = S_HALT;
`else
                // Unreachable without the trap; recover to a sane state.
                state_d = S_FETCH;
`endif
            end
            default:  state_d = S_FETCH;
        endcase
    end

    // Selects depend only on the latched class once decode has happened, so
    // the datapath sees them stable through every execution state.
    assign post_decode = (state_q != S_FETCH) && (state_q != S_DECODE);

    always_comb begin
        pc_wr      = 1'b0;
        npc_sel    = NPC_PC4;
        ir_wr      = 1'b0;
        reg_wr     = 1'b0;
        mem_wr     = 1'b0;
        reg_dst    = DST_RT;
        alu_src    = 1'b0;
        alu_op     = ALU_ADD;
        ext_op     = 1'b0;
        mem_to_reg = M2R_ALU;

        if (post_decode) begin
            alu_src = cls.lw || cls.sw || cls.ori || cls.lui;
            ext_op  = cls.lw || cls.sw;
            if (cls.lui)                  alu_op = ALU_LUI;
            else if (cls.ori)             alu_op = ALU_OR;
            else if (cls.sub || cls.beq)  alu_op = ALU_SUB;
            if (cls.r_arith)              reg_dst = DST_RD;
            else if (cls.jal)             reg_dst = DST_R31;
            if (cls.lw)                   mem_to_reg = M2R_MEM;
            else if (cls.jal)             mem_to_reg = M2R_PC4;
        end

        case (state_q)
            S_FETCH: ir_wr = 1'b1;
            S_WBM, S_WBA: begin
                pc_wr  = 1'b1;
                reg_wr = 1'b1;
            end
            S_MW: begin
                pc_wr  = 1'b1;
                mem_wr = 1'b1;
            end
            S_BR: begin
                pc_wr   = 1'b1;
                npc_sel = zero ? NPC_BRANCH : NPC_PC4;
            end
            S_JMP: begin
                pc_wr   = 1'b1;
                npc_sel = cls.jr ? NPC_REG : NPC_JUMP;
                reg_wr  = cls.jal;
            end
            S_ILL: pc_wr = 1'b1;
            default: ;
        endcase
    end

    assign state   = state_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: scoreboard bench for mc_controller. A driver issues one
// instruction at a time and pushes the expected completion record; a monitor
// counts cycles and compares on every pc_wr strobe.
module tb_mc_controller;

    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic [31:0]      instruction;
    logic             zero;
    logic             pc_wr;
    logic [1:0]       npc_sel;
    logic             ir_wr;
    logic             reg_wr;
    logic [1:0]       reg_dst;
    logic             alu_src;
    logic [1:0]       alu_op;
    logic             ext_op;
    logic             mem_wr;
    logic [1:0]       mem_to_reg;
    logic [3:0]       state;
    logic [CNT_W-1:0] retired;

    mc_controller #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .instruction (instruction),
        .zero        (zero),
        .pc_wr       (pc_wr),
        .npc_sel     (npc_sel),
        .ir_wr       (ir_wr),
        .reg_wr      (reg_wr),
        .reg_dst     (reg_dst),
        .alu_src     (alu_src),
        .alu_op      (alu_op),
        .ext_op      (ext_op),
        .mem_wr      (mem_wr),
        .mem_to_reg  (mem_to_reg),
        .state       (state),
        .retired     (retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cycles;
        logic [1:0]  npc;
        logic        reg_wr;
        logic [1:0]  reg_dst;
        logic [1:0]  m2r;
        int          mem_wr_cnt;
        logic        chk_alu;
        logic        alu_src;
        logic [1:0]  alu_op;
        logic        chk_ext;
        logic        ext_op;
        logic [31:0] ret;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_ret  = 0;
    bit          halt_test = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: what an instruction must look like at its completing cycle,
    // derived from the instruction-set rules (cycle counts, selects, strobes).
    function automatic exp_t model(input logic [31:0] ins, input logic z, input logic [31:0] ret);
        exp_t e;
        logic [5:0] op;
        logic [5:0] fn;
        op = ins[31:26];
        fn = ins[5:0];
        e = '{cycles: 3, npc: 2'b00, reg_wr: 1'b0, reg_dst: 2'b00, m2r: 2'b00,
              mem_wr_cnt: 0, chk_alu: 1'b0, alu_src: 1'b0, alu_op: 2'b00,
              chk_ext: 1'b0, ext_op: 1'b0, ret: ret};
        case (op)
            6'h00: begin
                if (fn == 6'h21 || fn == 6'h23) begin
                    e.cycles = 4; e.reg_wr = 1; e.reg_dst = 2'b01;
                    e.chk_alu = 1; e.alu_src = 0;
                    e.alu_op = (fn == 6'h23) ? 2'b01 : 2'b00;
                end else if (fn == 6'h08) begin
                    e.npc = 2'b01;
                end
            end
            6'h0D, 6'h0F: begin
                e.cycles = 4; e.reg_wr = 1;
                e.chk_alu = 1; e.alu_src = 1;
                e.alu_op = (op == 6'h0F) ? 2'b11 : 2'b10;
                e.chk_ext = 1; e.ext_op = 0;
            end
            6'h23: begin
                e.cycles = 5; e.reg_wr = 1; e.m2r = 2'b01;
                e.chk_alu = 1; e.alu_src = 1; e.chk_ext = 1; e.ext_op = 1;
            end
            6'h2B: begin
                e.cycles = 4; e.mem_wr_cnt = 1;
                e.chk_alu = 1; e.alu_src = 1; e.chk_ext = 1; e.ext_op = 1;
            end
            6'h04: begin
                e.npc = z ? 2'b11 : 2'b00;
                e.chk_alu = 1; e.alu_src = 0; e.alu_op = 2'b01;
            end
            6'h02: e.npc = 2'b10;
            6'h03: begin
                e.npc = 2'b10; e.reg_wr = 1; e.reg_dst = 2'b10; e.m2r = 2'b10;
            end
            default: ;
        endcase
        return e;
    endfunction

    // Monitor: cycle accounting per instruction, comparison on each pc_wr.
    int   cyc = 0;
    int   mw_cnt = 0;
    int   rw_early = 0;
    exp_t mon_e;

    always @(negedge clk) begin
        if (reset || halt_test) begin
            cyc = 0; mw_cnt = 0; rw_early = 0;
        end else begin
            cyc++;
            if (cyc == 1) begin
                check("ir_wr_fetch", 32'(ir_wr), 32'd1);
                check("state_fetch", 32'(state), 32'd0);
            end else begin
                check("ir_wr_late", 32'(ir_wr), 32'd0);
            end
            mw_cnt += int'(mem_wr);
            if (!pc_wr) begin
                if (reg_wr) rw_early++;
                check("npc_idle", 32'(npc_sel), 32'd0);
            end else begin
                if (sb.size() == 0) begin
                    check("unexpected_pc_wr", 32'd1, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("cycles", cyc, mon_e.cycles);
                    check("npc_sel", 32'(npc_sel), 32'(mon_e.npc));
                    check("reg_wr", 32'(reg_wr), 32'(mon_e.reg_wr));
                    check("reg_wr_early", rw_early, 0);
                    check("mem_wr_cnt", mw_cnt, mon_e.mem_wr_cnt);
                    check("retired", retired, mon_e.ret);
                    if (mon_e.reg_wr) begin
                        check("reg_dst", 32'(reg_dst), 32'(mon_e.reg_dst));
                        check("mem_to_reg", 32'(mem_to_reg), 32'(mon_e.m2r));
                    end
                    if (mon_e.chk_alu) begin
                        check("alu_src", 32'(alu_src), 32'(mon_e.alu_src));
                        check("alu_op", 32'(alu_op), 32'(mon_e.alu_op));
                    end
                    if (mon_e.chk_ext) check("ext_op", 32'(ext_op), 32'(mon_e.ext_op));
                end
                cyc = 0; mw_cnt = 0; rw_early = 0;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #2;
        reset = 1'b1;
        sb.delete();
        exp_ret = 0;
        @(negedge clk);
        check("rst_state", 32'(state), 32'd0);
        check("rst_retired", retired, 32'd0);
        check("rst_ir_wr", 32'(ir_wr), 32'd1);
        check("rst_pc_wr", 32'(pc_wr), 32'd0);
        check("rst_npc", 32'(npc_sel), 32'd0);
        check("rst_wr_en", 32'({reg_wr, mem_wr}), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("post_rst_state", 32'(state), 32'd0);
        check("post_rst_retired", retired, 32'd0);
        check("post_rst_ir_wr", 32'(ir_wr), 32'd1);
        check("post_rst_pc_wr", 32'(pc_wr), 32'd0);
    endtask

    // Called inside a FETCH cycle, before the edge that latches the word.
    // abort_at > 0 pulls reset during that cycle of the instruction.
    task automatic run_instr(input logic [31:0] ins, input logic z, input int abort_at);
        exp_t e;
        int   k;
        bit   done;
        e = model(ins, z, exp_ret);
        exp_ret++;
        sb.push_back(e);
        instruction = ins;
        done = 0;
        k = 1;
        while (!done && k <= 8) begin
            zero = (ins[31:26] == 6'h04 && k == 3) ? z : 1'($urandom);
            if (k == abort_at) begin
                @(negedge clk);
                check("state_mr", 32'(state), 32'd3);
                do_reset();
                return;
            end
            @(negedge clk);
            if (pc_wr) done = 1;
            @(posedge clk); #1;
            k++;
        end
        if (!done) begin
            check("instr_timeout", 32'd0, 32'd1);
            do_reset();
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [5:0]  bad_ops [6];
        int          c;
        bad_ops = '{6'h3F, 6'h01, 6'h05, 6'h08, 6'h10, 6'h2A};
        w = $urandom;
`ifdef MC_ILLEGAL_TRAP_EN
        c = $urandom_range(0, 9);
`else
        c = $urandom_range(0, 11);
`endif
        case (c)
            0:  begin w[31:26] = 6'h00; w[5:0] = 6'h21; end
            1:  begin w[31:26] = 6'h00; w[5:0] = 6'h23; end
            2:  begin w[31:26] = 6'h00; w[5:0] = 6'h08; end
            3:  w[31:26] = 6'h0D;
            4:  w[31:26] = 6'h0F;
            5:  w[31:26] = 6'h23;
            6:  w[31:26] = 6'h2B;
            7:  w[31:26] = 6'h04;
            8:  w[31:26] = 6'h02;
            9:  w[31:26] = 6'h03;
            10: w[31:26] = bad_ops[$urandom_range(0, 5)];
            default: begin w[31:26] = 6'h00; w[5:4] = 2'b11; end
        endcase
        return w;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        instruction = 32'h0;
        zero = 1'b0;
        do_reset();

        run_instr(32'h00851021, 1'b0, 0);  // addu
        run_instr(32'h8C820004, 1'b0, 0);  // lw
        run_instr(32'hAC820004, 1'b0, 0);  // sw
        run_instr(32'h10850003, 1'b1, 0);  // beq taken
        run_instr(32'h10850003, 1'b0, 0);  // beq not taken
        run_instr(32'h0C000C00, 1'b0, 0);  // jal
        run_instr(32'h03E00008, 1'b0, 0);  // jr
        run_instr(32'h08000C00, 1'b0, 0);  // j
        run_instr(32'h3482000F, 1'b0, 0);  // ori
        run_instr(32'h3C021234, 1'b0, 0);  // lui
        run_instr(32'h00851023, 1'b0, 0);  // subu
`ifndef MC_ILLEGAL_TRAP_EN
        run_instr(32'hFC000000, 1'b0, 0);  // illegal nop
        run_instr(32'h00851021, 1'b0, 0);  // retired must reflect the nop
`endif

        // Reset in the MR cycle of a lw abandons it.
        run_instr(32'h8C820004, 1'b0, 4);
        run_instr(32'h00851021, 1'b0, 0);

`ifdef MC_ILLEGAL_TRAP_EN
        halt_test = 1;
        instruction = 32'hFC000000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("halt_state", 32'(state), 32'hF);
            check("halt_en", 32'({pc_wr, ir_wr, reg_wr, mem_wr}), 32'd0);
            check("halt_retired", retired, exp_ret);
        end
        do_reset();
        halt_test = 0;
`endif

        for (int n = 0; n < 300; n++) begin
            run_instr(rand_instr(), 1'($urandom), 0);
        end

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multi-cycle control FSM sitting directly downstream of the instruction fetch unit. It captures the fetched instruction's opcode/funct, steps each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK states, and drives the datapath write enables and selects. It produces `pc_wr` and `npc_sel`, which the fetch unit consumes to advance the PC exactly once per instruction.

## Interface
Parameters:
- `CNT_W`, 32: width of the retired-instruction counter.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high
- `instruction`  in  32  fetched word, stable while PC is unchanged
- `zero`  in  1  ALU equality flag, valid in BR state
- `pc_wr`  out  1  PC update strobe to fetch unit
- `npc_sel`  out  2  00 PC+4, 01 register (jr), 10 jump target, 11 branch target
- `ir_wr`  out  1  instruction register load
- `reg_wr`  out  1  register file write
- `reg_dst`  out  2  00 rt, 01 rd, 10 r31
- `alu_src`  out  1  0 register, 1 extended immediate
- `alu_op`  out  2  00 add, 01 sub, 10 or, 11 lui
- `ext_op`  out  1  0 zero-extend, 1 sign-extend
- `mem_wr`  out  1  data memory write
- `mem_to_reg`  out  2  00 ALU, 01 memory, 10 PC+4
- `state`  out  4  current state encoding, for debug
- `retired`  out  CNT_W  count of completed instructions

## Operation
- Supported: addu, subu (op 0, funct 21h/23h), jr (op 0, funct 08h), ori 0Dh, lui 0Fh, lw 23h, sw 2Bh, beq 04h, j 02h, jal 03h.
- op/funct are latched into internal registers at the FETCH→DECODE edge (`ir_wr`=1 in FETCH). Later decode uses the latched copy only.
- States and transitions:
  - FETCH→DECODE always.
  - DECODE: lw/sw→MA; R-type arith, ori, lui→EXE; beq→BR; j/jal/jr→JMP; other→ILL.
  - MA: lw→MR, sw→MW.
  - MR→WBM.
  - EXE→WBA.
  - WBM, WBA, MW, BR, JMP→FETCH.
- `pc_wr`=1 only in the final state of each instruction (WBM, WBA, MW, BR, JMP, ILL-nop). `npc_sel`=00 there, except:
  - BR: 11 if `zero`, else 00.
  - JMP: 10 for j/jal, 01 for jr.
- WBA: `reg_wr`=1, `reg_dst`=01 for R-type, 00 for ori/lui.
- WBM: `reg_wr`=1, `reg_dst`=00, `mem_to_reg`=01.
- JMP with jal: `reg_wr`=1, `reg_dst`=10, `mem_to_reg`=10.
- MW: `mem_wr`=1.
- `alu_src`/`ext_op`:
  - lw/sw: 1/1.
  - ori: 1/0.
  - lui: 1/0 with `alu_op`=11.
  - BR: `alu_src`=0, `alu_op`=01.
- Selects are held per the latched op in every post-DECODE state. Enables are zero outside the states listed above.
- `retired` increments by 1 on every cycle where `pc_wr`=1. It wraps modulo 2^CNT_W.

## Timing
- Cycles per instruction:
  - lw: 5.
  - R-type, ori, lui, sw: 4.
  - beq, j, jal, jr: 3.
  - illegal: 3.
- Outputs are combinational from state, latched op/funct and `zero`. `state` and `retired` are registered.
- Reset (async) forces FETCH, clears latched op/funct and `retired`. During and immediately after reset, all enables are 0 except `ir_wr`=1 (FETCH), and `npc_sel`=00.
- Reset mid-instruction abandons it: no `pc_wr`, no counter increment.
- `zero` is sampled only in BR. Changes elsewhere have no effect.

## Configuration
- `MC_ILLEGAL_TRAP_EN` defined: an unknown opcode/funct enters HALT (state Fh).
  - HALT has all enables 0 and `pc_wr`=0, and holds until reset.
  - `retired` is frozen while in HALT.
- Undefined: unknown encodings go to ILL, which performs a nop.
  - ILL asserts `pc_wr`=1 with `npc_sel`=00, then returns to FETCH.

## Structure
- Shared package/header holds:
  - State encodings: FETCH 0, DECODE 1, MA 2, MR 3, MW 4, WBM 5, EXE 6, WBA 7, BR 8, JMP 9, ILL Ah, HALT Fh.
  - Opcode and funct constants.
  - `npc_sel`, `alu_op`, `reg_dst`, `mem_to_reg` codes.
- One sub-module, `mc_decode`: combinational op/funct → instruction-class flags. The FSM and output logic stay in `mc_controller`.

## Test plan
- Reset asserted mid-MR of lw, released → state=0, `retired`=0, `ir_wr`=1, `pc_wr`=0.
- addu (00851021h) → 4 cycles. `reg_wr`=1, `reg_dst`=01 in cycle 4. `pc_wr`=1, `npc_sel`=00 in cycle 4 only. `retired`=1.
- lw (8C820004h) then sw (AC820004h) → 5 then 4 cycles. `mem_to_reg`=01 in WBM. `mem_wr`=1 only in MW. `retired`=2.
- beq (10850003h):
  - `zero`=1 → `npc_sel`=11 in cycle 3.
  - Repeat with `zero`=0 → `npc_sel`=00.
- jal (0C000C00h) → cycle 3: `npc_sel`=10, `reg_wr`=1, `reg_dst`=10, `mem_to_reg`=10.
- jr (03E00008h) → cycle 3: `npc_sel`=01.
- Opcode 3Fh:
  - Without the macro → `pc_wr`=1 in cycle 3, `retired` increments.
  - With the macro → `state`=Fh held for 10 cycles, all enables 0.
